// File: rtl/mem_pkg.sv
// Shared types for the load/store data memory:
// funct3 codes, FSM states and the lane-mask helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // size is funct3[1:0]: 0 byte, 1 half, otherwise word
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] m;
        unique case (size)
            2'd0:    m = 4'b0001 << lane;
            2'd1:    m = 4'b0011 << lane;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus of the data memory.
// master drives requests, slave is the memory.
interface data_memory_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;
    logic [3:0]      rvfi_rmask;
    logic [3:0]      rvfi_wmask;

    modport master (
        output req_valid, req_write, req_funct3,
        output req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata,
        input  resp_fault, rvfi_rmask, rvfi_wmask
    );

    modport slave (
        input  req_valid, req_write, req_funct3,
        input  req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata,
        output resp_fault, rvfi_rmask, rvfi_wmask
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extends load data from the addressed
// lanes and shifts store data into them.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] sword,
    output logic [3:0]  bmask,
    output logic        misalign
);

    logic [4:0]  bit_off;
    logic [31:0] sh;

    assign bit_off  = {lane, 3'b000};
    assign sh       = rword >> bit_off;
    assign sword    = wdata << bit_off;
    assign bmask    = lane_mask(funct3[1:0], lane);
    assign misalign = (funct3[1:0] == 2'd1 && lane[0]) ||
                      (funct3[1:0] == 2'd2 && lane != 2'd0);

    always_comb begin
        ldata = '0;
        unique case (funct3)
            F3_B:    ldata = {{24{sh[7]}}, sh[7:0]};
            F3_H:    ldata = {{16{sh[15]}}, sh[15:0]};
            F3_W:    ldata = sh;
            F3_BU:   ldata = {24'd0, sh[7:0]};
            F3_HU:   ldata = {16'd0, sh[15:0]};
            default: ldata = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory with one outstanding request,
// configurable latency and fault/RVFI mask reporting.
module data_memory
    import mem_pkg::*;
#(
    parameter int MEMSIZE = 64,
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input logic          clk,
    input logic          rst,
    data_memory_if.slave bus
);

    localparam int AW = $clog2(MEMSIZE);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [XLEN-3:0] DEPTH = (XLEN-2)'(MEMSIZE);

    logic [XLEN-1:0] mem [MEMSIZE];

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            vld_q;
    logic            fault_q;
    logic [XLEN-1:0] rdata_q;
    logic [3:0]      rmask_q;
    logic [3:0]      wmask_q;

    logic [AW-1:0]   idx;
    logic [XLEN-1:0] rword;
    logic [XLEN-1:0] ldata;
    logic [XLEN-1:0] sword;
    logic [3:0]      bmask;
    logic            misalign;
    logic            oor;
    logic            illegal;
    logic            fault;
    logic            accept;
    logic            wr_en;

    assign idx   = bus.req_addr[AW+1:2];
    assign rword = mem[idx];

    mem_lane_align u_align (
        .funct3   (bus.req_funct3),
        .lane     (bus.req_addr[1:0]),
        .rword    (rword),
        .wdata    (bus.req_wdata),
        .ldata    (ldata),
        .sword    (sword),
        .bmask    (bmask),
        .misalign (misalign)
    );

    assign oor     = bus.req_addr[XLEN-1:2] >= DEPTH;
    assign illegal = bus.req_write ? (bus.req_funct3 >= 3'd3)
                   : (bus.req_funct3 == 3'd3 ||
                      bus.req_funct3 >= 3'd6);
    assign fault   = misalign || oor || illegal;

    // In RESP a new request slips in only when the response drains
    assign bus.req_ready = !rst && (state == IDLE ||
                           (state == RESP && bus.resp_ready));
    assign accept = bus.req_valid && bus.req_ready;
    assign wr_en  = accept && bus.req_write && !fault;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && bmask[i]) begin
                mem[idx][8*i +: 8] <= sword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        fault_q <= fault;
                        rdata_q <= (bus.req_write || fault) ? '0 : ldata;
                        rmask_q <= (bus.req_write || fault) ? 4'd0 : bmask;
                        wmask_q <= (bus.req_write && !fault) ? bmask : 4'd0;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            vld_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                            vld_q <= 1'b0;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end else if (state == RESP && bus.resp_ready) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                        vld_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = vld_q;
    assign bus.resp_fault = fault_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.rvfi_rmask = rmask_q;
    assign bus.rvfi_wmask = wmask_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed scoreboard bench for data_memory at
// latencies 1, 3 and 4 behind one shared driver.
module tb_data_memory;
    import mem_pkg::*;

    typedef logic [40:0] exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        rv  = 1'b0;
    logic        rw  = 1'b0;
    logic        rr  = 1'b0;
    logic [2:0]  rf3 = 3'd0;
    logic [31:0] ra  = '0;
    logic [31:0] rwd = '0;

    logic [42:0] o1, o3, o4, o;
    logic        rq, sv;
    exp_t        held;
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;

    data_memory_if b1();
    data_memory_if b3();
    data_memory_if b4();

    data_memory #(.MEMSIZE(64), .XLEN(32), .LATENCY(1)) d1 (
        .clk(clk), .rst(rst), .bus(b1));
    data_memory #(.MEMSIZE(64), .XLEN(32), .LATENCY(3)) d3 (
        .clk(clk), .rst(rst), .bus(b3));
    data_memory #(.MEMSIZE(64), .XLEN(32), .LATENCY(4)) d4 (
        .clk(clk), .rst(rst), .bus(b4));

    assign b1.req_valid  = rv && sel == 0;
    assign b3.req_valid  = rv && sel == 1;
    assign b4.req_valid  = rv && sel == 2;
    assign b1.resp_ready = rr && sel == 0;
    assign b3.resp_ready = rr && sel == 1;
    assign b4.resp_ready = rr && sel == 2;
    assign {b1.req_write, b1.req_funct3, b1.req_addr, b1.req_wdata} = {rw, rf3, ra, rwd};
    assign {b3.req_write, b3.req_funct3, b3.req_addr, b3.req_wdata} = {rw, rf3, ra, rwd};
    assign {b4.req_write, b4.req_funct3, b4.req_addr, b4.req_wdata} = {rw, rf3, ra, rwd};

    assign o1 = {b1.req_ready, b1.resp_valid, b1.resp_rdata,
                 b1.resp_fault, b1.rvfi_rmask, b1.rvfi_wmask};
    assign o3 = {b3.req_ready, b3.resp_valid, b3.resp_rdata,
                 b3.resp_fault, b3.rvfi_rmask, b3.rvfi_wmask};
    assign o4 = {b4.req_ready, b4.resp_valid, b4.resp_rdata,
                 b4.resp_fault, b4.rvfi_rmask, b4.rvfi_wmask};
    assign o  = (sel == 1) ? o3 : (sel == 2) ? o4 : o1;
    assign rq = o[42];
    assign sv = o[41];

    function automatic exp_t E(input logic [31:0] d, input logic f,
                               input logic [3:0] rm, input logic [3:0] wm);
        return {d, f, rm, wm};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input exp_t obs, input exp_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (q.size() == 0) begin
            chk1({tag, ".queue"}, 1'b0, 1'b1);
        end else begin
            chkd(tag, o[40:0], q.pop_front());
        end
    endtask

    // One full transaction: push expectation, drive, wait, compare
    task automatic do_op(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input exp_t e);
        int n;
        q.push_back(e);
        @(negedge clk);
        rv = 1'b1; rw = w; rf3 = f3; ra = a; rwd = wd;
        n = 0;
        while (!rq && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rv = 1'b0;
        @(negedge clk);
        n = 0;
        while (!sv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, ".valid"}, sv, 1'b1);
        pop_chk(tag);
        rr = 1'b1;
        @(posedge clk);
        #1 rr = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_valid", sv, 1'b0);
        chkd("rst_outs", o[40:0], '0);
        chk1("rst_ready", rq, 1'b1);

        // word store and readback
        do_op("sw08", 1'b1, F3_W, 32'h08, 32'hDEADBEEF, E(0, 0, 0, 4'hF));
        do_op("lw08", 1'b0, F3_W, 32'h08, 0, E(32'hDEADBEEF, 0, 4'hF, 0));

        // byte store and sign/zero extension
        do_op("sw0c", 1'b1, F3_W, 32'h0C, 0, E(0, 0, 0, 4'hF));
        do_op("sb0d", 1'b1, F3_B, 32'h0D, 32'h80, E(0, 0, 0, 4'b0010));
        do_op("lb0d", 1'b0, F3_B, 32'h0D, 0, E(32'hFFFFFF80, 0, 4'b0010, 0));
        do_op("lbu0d", 1'b0, F3_BU, 32'h0D, 0, E(32'h00000080, 0, 4'b0010, 0));
        do_op("lw0c", 1'b0, F3_W, 32'h0C, 0, E(32'h00008000, 0, 4'hF, 0));
        do_op("lh0c", 1'b0, F3_H, 32'h0C, 0, E(32'hFFFF8000, 0, 4'b0011, 0));
        do_op("lhu0c", 1'b0, F3_HU, 32'h0C, 0, E(32'h00008000, 0, 4'b0011, 0));
        do_op("sh0e", 1'b1, F3_H, 32'h0E, 32'h1234ABCD, E(0, 0, 0, 4'b1100));
        do_op("lw0c2", 1'b0, F3_W, 32'h0C, 0, E(32'hABCD8000, 0, 4'hF, 0));

        // faults leave memory untouched
        do_op("sw04", 1'b1, F3_W, 32'h04, 32'h55AA55AA, E(0, 0, 0, 4'hF));
        do_op("lh03", 1'b0, F3_H, 32'h03, 0, E(0, 1, 0, 0));
        do_op("sh05", 1'b1, F3_H, 32'h05, 32'hFFFF, E(0, 1, 0, 0));
        do_op("sw06", 1'b1, F3_W, 32'h06, 32'hFFFFFFFF, E(0, 1, 0, 0));
        do_op("ill_ld3", 1'b0, 3'd3, 32'h04, 0, E(0, 1, 0, 0));
        do_op("ill_st4", 1'b1, 3'd4, 32'h04, 32'h0, E(0, 1, 0, 0));
        do_op("oor_sw", 1'b1, F3_W, 32'h100, 32'h0, E(0, 1, 0, 0));
        do_op("lw04", 1'b0, F3_W, 32'h04, 0, E(32'h55AA55AA, 0, 4'hF, 0));
        do_op("oor_lw", 1'b0, F3_W, 32'h100, 0, E(0, 1, 0, 0));

        // back-to-back loads at LATENCY 1
        for (int i = 0; i < 4; i++) begin
            do_op("t5fill", 1'b1, F3_W, 32'h20 + 32'(4 * i),
                  32'hA5000000 + 32'(i), E(0, 0, 0, 4'hF));
        end
        rr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk1("t5valid", sv, 1'b1);
                pop_chk("t5data");
            end
            if (i < 4) begin
                rv = 1'b1; rw = 1'b0; rf3 = F3_W;
                ra = 32'h20 + 32'(4 * i);
                q.push_back(E(32'hA5000000 + 32'(i), 0, 4'hF, 0));
            end else begin
                rv = 1'b0;
            end
        end
        @(negedge clk);
        chk1("t5drain", sv, 1'b0);
        rr = 1'b0;

        // LATENCY 3 timing and stall hold
        sel = 1;
        do_op("t4sw", 1'b1, F3_W, 32'h00, 32'h0BADF00D, E(0, 0, 0, 4'hF));
        q.push_back(E(32'h0BADF00D, 0, 4'hF, 0));
        @(negedge clk);
        rv = 1'b1; rw = 1'b0; rf3 = F3_W; ra = 32'h00;
        chk1("t4rdy", rq, 1'b1);
        @(posedge clk);
        #1 rv = 1'b0;
        @(negedge clk);
        chk1("t4v_e0", sv, 1'b0);
        chk1("t4r_e0", rq, 1'b0);
        @(negedge clk);
        chk1("t4v_e1", sv, 1'b0);
        chk1("t4r_e1", rq, 1'b0);
        @(negedge clk);
        chk1("t4v_e2", sv, 1'b1);
        chk1("t4r_e2", rq, 1'b0);
        held = o[40:0];
        pop_chk("t4data");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("t4hold_v", sv, 1'b1);
            chk1("t4hold_r", rq, 1'b0);
            chkd("t4hold_d", o[40:0], held);
        end
        rr = 1'b1;
        #1 chk1("t4rdy_pass", rq, 1'b1);
        @(posedge clk);
        #1 rr = 1'b0;
        @(negedge clk);
        chk1("t4idle", sv, 1'b0);

        // reset during WAIT and during RESP at LATENCY 4
        sel = 2;
        do_op("t6sw", 1'b1, F3_W, 32'h10, 32'h12345678, E(0, 0, 0, 4'hF));
        @(negedge clk);
        rv = 1'b1; rw = 1'b0; rf3 = F3_W; ra = 32'h10;
        @(posedge clk);
        #1 rv = 1'b0;
        @(negedge clk);
        chk1("t6wait_r", rq, 1'b0);
        rst = 1'b1;
        #1 chk1("t6rst_v", sv, 1'b0);
        chkd("t6rst_o", o[40:0], '0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk1("t6rdy", rq, 1'b1);
        do_op("t6lw", 1'b0, F3_W, 32'h10, 0, E(32'h12345678, 0, 4'hF, 0));
        @(negedge clk);
        rv = 1'b1; rw = 1'b0; rf3 = F3_W; ra = 32'h10;
        @(posedge clk);
        #1 rv = 1'b0;
        n = 0;
        while (!sv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("t6resp_v", sv, 1'b1);
        rst = 1'b1;
        #1 chk1("t6rst_resp", sv, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk1("t6idle_v", sv, 1'b0);
        chk1("t6idle_r", rq, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised, byte-addressed RISC-V data memory for the load/store stage. It accepts one load or store per request over a valid/ready handshake and decodes `funct3` into byte, half and word accesses with sign or zero extension. It applies configurable access latency and flags misaligned, out-of-range and illegal accesses. It emits RVFI byte-lane masks aligned to the addressed lanes.

## Interface
Parameters:
- `MEMSIZE`, 64: depth in `XLEN`-bit words; power of two, ≥ 2.
- `XLEN`, 32: data and address width; fixed at 32 in this generation.
- `LATENCY`, 1: cycles from request accept to `resp_valid`; ≥ 1.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I load/store `funct3`.
- `req_addr` in `XLEN`: byte address.
- `req_wdata` in `XLEN`: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed when `resp_valid && resp_ready`.
- `resp_rdata` out `XLEN`: extended load data; 0 for stores and faults.
- `resp_fault` out 1: access rejected.
- `rvfi_rmask` out 4: lanes read, shifted by `addr[1:0]`.
- `rvfi_wmask` out 4: lanes written, shifted by `addr[1:0]`.

## Operation
Address decode:
- Word index = `addr[$clog2(MEMSIZE)+1:2]`.
- Lane = `addr[1:0]`.

Loads:
- `funct3` 0/1/2/4/5 = LB/LH/LW/LBU/LHU.
- Extract the addressed byte or half from the word, then sign-extend (0/1) or zero-extend (4/5).

Stores:
- `funct3` 0/1/2 = SB/SH/SW.
- Write only the addressed lanes from the low bytes of `req_wdata`; other lanes keep their value.

Fault conditions (any of):
- Half access with `addr[0]`=1.
- Word access with `addr[1:0]`≠0.
- `addr[XLEN-1:2]` ≥ `MEMSIZE`.
- Load `funct3` ∈ {3,6,7}, or store `funct3` ≥ 3.

On fault: no memory write, `resp_rdata`=0, both masks 0, `resp_fault`=1.

Masks for good accesses: byte = `0001<<lane`, half = `0011<<lane`, word = `1111`. `rmask` is 0 for stores; `wmask` is 0 for loads.

FSM states:
- IDLE: `req_ready`=1. On accept, go to RESP if `LATENCY`=1, else go to WAIT with counter = `LATENCY`-1.
- WAIT: `req_ready`=0; counter decrements each cycle; go to RESP when counter reaches 1.
- RESP: `resp_valid`=1; all response outputs held stable until consumed. On consume: accept a new request in the same cycle if `req_valid` (`req_ready` = `resp_ready` in RESP), else go to IDLE.

Other rules:
- One outstanding request; no reordering.

## Timing
- Memory read and store commit both happen at the accept edge. Response fields are registered at that edge and carried to RESP.
- Accept at edge N → `resp_valid` high in the cycle after edge N+`LATENCY`-1 (`LATENCY`=1: the next cycle).
- With `LATENCY`=1 and `resp_ready` held high, throughput is one access per cycle.
- A load following a store to the same word returns the stored data (commit precedes the next read edge).
- Reset values: state IDLE; `resp_valid`, `resp_fault` = 0; `resp_rdata` = 0; `rvfi_rmask`, `rvfi_wmask` = 0; counter 0; `req_ready` = 1 once `rst` deasserts.
- Memory array is not reset.
- Reset mid-operation: `resp_valid` drops asynchronously and the pending response is discarded. A store already accepted stays committed.
- Changes on `req_*` while not accepted have no effect.

## Structure
Package `mem_pkg`:
- `funct3` constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- FSM state enum (IDLE/WAIT/RESP).
- Lane-mask function taking size and `addr[1:0]`.

Sub-module `mem_lane_align`, combinational:
- Inputs: `funct3`, `addr[1:0]`, read word, `wdata`.
- Outputs: extended load data, shifted store word, byte mask, misalign flag.

The top level holds the array, FSM, latency counter and response registers.

## Test plan
1. SW 0xDEADBEEF @0x08, then LW @0x08 → `rdata` 0xDEADBEEF; `wmask` 1111 then `rmask` 1111; `fault` 0.
2. Word @0x0C = 0; SB 0x80 @0x0D; then LB @0x0D, then LBU @0x0D:
   - LB → 0xFFFFFF80; LBU → 0x00000080.
   - `wmask` and `rmask` 0010; word @0x0C reads 0x00008000.
3. LH @0x03 → `fault` 1, `rdata` 0, masks 0. SH 0xFFFF @0x05 → `fault` 1; LW @0x04 unchanged. LW @4×`MEMSIZE` → `fault` 1.
4. `LATENCY`=3, accept at edge 0 → `resp_valid` after edge 2; hold `resp_ready` low 2 cycles → outputs stable and `req_ready` 0 throughout.
5. `LATENCY`=1, `resp_ready` tied 1: four back-to-back loads → four consecutive `resp_valid` cycles in order, no bubbles.
6. SW 0x12345678 @0x10, then LW @0x10; assert `rst` during WAIT (`LATENCY`=4) → `resp_valid` 0 immediately; after release, LW @0x10 → 0x12345678.
